// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the CPU run controller: state encoding, run modes,
// default cycle cap and the CPU reset vector.
// No logic; imported by the controller, its counter and the benches.
package cpu_run_controller_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_STEP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_INIT  = ST_INIT,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_STEP  = ST_STEP,
    S_DONE  = ST_DONE
  } state_t;

  typedef enum logic {
    MODE_FREE = 1'b0,
    MODE_STEP = 1'b1
  } run_mode_t;

  localparam int          DEFAULT_MAX_CYCLES = 5000;
  localparam logic [31:0] CPU_RESET_VEC      = 32'h0040_0000;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Control/status bundle between run-control master (top level, bench, debug)
// and the run controller. master drives commands and regPC; slave reports
// enables and status. Purely wiring, no latency.
interface cpu_run_controller_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             step;
  logic             halt_req;
  logic [31:0]      pc_lim;
  logic [31:0]      regPC;
  logic             cpu_en;
  logic             cpu_init;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, step, halt_req, pc_lim, regPC,
    input  cpu_en, cpu_init, busy, done, timeout, cycle_count
  );

  modport slave (
    input  start, step, halt_req, pc_lim, regPC,
    output cpu_en, cpu_init, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/cpu_run_controller_sat_cycle_counter.sv
// Saturating up-counter of enabled CPU cycles; clr wins over inc.
// Latency: count updates one clock after clr/inc.
// Ports: clk, clr, inc in; count out (CNT_W). No backpressure; stops at MAX.
module sat_cycle_counter
  import cpu_run_controller_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int MAX   = DEFAULT_MAX_CYCLES
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + ONE;
    end
  end
endmodule

// File: rtl/cpu_run_controller.sv
// Sequences the CPU: holds initPC, then gates advance per free-run or step mode.
// Latency: step pulse -> cpu_en one cycle later; cpu_en drops same cycle term rises.
// Ports: clk, initPC (sync reset, passed through to cpu_init); ctl bundle (slave).
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int MAX_CYCLES  = DEFAULT_MAX_CYCLES,
  parameter int INIT_CYCLES = 1,
  parameter int CNT_W       = 32
) (
  input logic                clk,
  input logic                initPC,
  cpu_run_controller_if.slave ctl
);
  localparam int               IW    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CYCLES);

  state_t           state_q, state_d;
  run_mode_t        mode_q, mode_d;
  logic [31:0]      lim_q;
  logic             done_q, timeout_q;
  logic [IW-1:0]    init_cnt;
  logic [CNT_W-1:0] count;
  logic             run_entry;
  logic             en_raw;
  logic             pc_hit, term;

  assign pc_hit = (ctl.regPC >= lim_q);
  assign term   = pc_hit || (count == MAX_V);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    run_entry = 1'b0;
    en_raw    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (ctl.start) begin
          state_d   = S_INIT;
          mode_d    = MODE_FREE;
          run_entry = 1'b1;
        end else if (ctl.step) begin
          state_d   = S_INIT;
          mode_d    = MODE_STEP;
          run_entry = 1'b1;
        end
      end
      S_INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_d = (mode_q == MODE_FREE) ? S_RUN : S_PAUSE;
        end
      end
      S_RUN: begin
        // The halt cycle itself still advances the CPU.
        en_raw = !term;
        if (term)              state_d = S_DONE;
        else if (ctl.halt_req) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        // term first: a limit reached by the last step closes the run.
        if (term)           state_d = S_DONE;
        else if (ctl.start) state_d = S_RUN;
        else if (ctl.step)  state_d = S_STEP;
      end
      S_STEP: begin
        en_raw  = !term;
        state_d = term ? S_DONE : S_PAUSE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (initPC) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_FREE;
      lim_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      init_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      init_cnt <= (state_q == S_INIT) ? init_cnt + IW'(1) : '0;
      if (run_entry) begin
        lim_q     <= ctl.pc_lim;
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
      end
      // PC limit takes precedence over the cycle cap when both hold.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        done_q    <= pc_hit;
        timeout_q <= !pc_hit;
      end
    end
  end

  sat_cycle_counter #(
    .CNT_W(CNT_W),
    .MAX  (MAX_CYCLES)
  ) u_cnt (
    .clk  (clk),
    .clr  (initPC || run_entry),
    .inc  (ctl.cpu_en),
    .count(count)
  );

  // initPC passes straight through so the CPU resets alongside the controller.
  assign ctl.cpu_en      = !initPC && en_raw;
  assign ctl.cpu_init    = initPC || (state_q == S_INIT);
  assign ctl.busy        = !initPC && ((state_q == S_INIT) || (state_q == S_RUN) ||
                                       (state_q == S_PAUSE) || (state_q == S_STEP));
  assign ctl.done        = done_q;
  assign ctl.timeout     = timeout_q;
  assign ctl.cycle_count = count;

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;
  import cpu_run_controller_pkg::*;

  localparam logic [31:0] LIM = 32'h0040_0054;

  logic clk = 1'b0;
  logic initPC;
  always #5 clk = ~clk;

  cpu_run_controller_if #(.CNT_W(32)) a ();
  cpu_run_controller_if #(.CNT_W(32)) b ();

  cpu_run_controller #(.MAX_CYCLES(5000), .INIT_CYCLES(1), .CNT_W(32)) dut_a (
    .clk(clk), .initPC(initPC), .ctl(a));
  cpu_run_controller #(.MAX_CYCLES(8), .INIT_CYCLES(1), .CNT_W(32)) dut_b (
    .clk(clk), .initPC(initPC), .ctl(b));

  // CPU model for dut_a: reset vector on init, +4 per enabled cycle.
  always @(posedge clk) begin
    if (a.cpu_init)    a.regPC <= CPU_RESET_VEC;
    else if (a.cpu_en) a.regPC <= a.regPC + 32'd4;
  end
  // dut_b sees a stuck PC.
  assign b.regPC = CPU_RESET_VEC;

  int clr_en;
  int en_a, en_b;
  always @(posedge clk) begin
    if (clr_en != 0) begin
      en_a <= 0;
      en_b <= 0;
    end else begin
      if (a.cpu_en) en_a <= en_a + 1;
      if (b.cpu_en) en_b <= en_b + 1;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_empty: observed 0x%0h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while (a.busy && n < budget) begin tick(1); n++; end
    push("wait_idle_a", 32'd0);
    check(32'(a.busy));
  endtask

  task automatic wait_idle_b(input int budget);
    int n = 0;
    while (b.busy && n < budget) begin tick(1); n++; end
    push("wait_idle_b", 32'd0);
    check(32'(b.busy));
  endtask

  task automatic wait_count_a(input logic [31:0] target, input int budget);
    int n = 0;
    while (a.cycle_count != target && n < budget) begin tick(1); n++; end
    push("wait_count_a", target);
    check(a.cycle_count);
  endtask

  task automatic clear_monitors();
    clr_en = 1;
    tick(1);
    clr_en = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    initPC = 1'b1;
    clr_en = 1;
    a.start = 1'b0; a.step = 1'b0; a.halt_req = 1'b0; a.pc_lim = '0;
    b.start = 1'b0; b.step = 1'b0; b.halt_req = 1'b0; b.pc_lim = '0;
    tick(2);

    // Reset state
    push("rst_cpu_init", 32'd1);  check(32'(a.cpu_init));
    push("rst_cpu_en", 32'd0);    check(32'(a.cpu_en));
    push("rst_busy", 32'd0);      check(32'(a.busy));
    push("rst_count", 32'd0);     check(a.cycle_count);
    push("rst_done", 32'd0);      check(32'(a.done));
    initPC = 1'b0;
    clr_en = 0;
    tick(1);
    push("idle_cpu_init", 32'd0); check(32'(a.cpu_init));

    // Free run to PC limit: 21 enables
    a.pc_lim = LIM;
    clear_monitors();
    a.start = 1'b1; tick(1); a.start = 1'b0;
    push("free_init_cpu_init", 32'd1); check(32'(a.cpu_init));
    push("free_init_busy", 32'd1);     check(32'(a.busy));
    wait_idle_a(200);
    push("free_done", 32'd1);     check(32'(a.done));
    push("free_timeout", 32'd0);  check(32'(a.timeout));
    push("free_count", 32'd21);   check(a.cycle_count);
    push("free_en_seen", 32'd21); check(32'(en_a));

    // Cycle cap with stuck PC on the MAX_CYCLES=8 instance
    b.pc_lim = LIM;
    clear_monitors();
    b.start = 1'b1; tick(1); b.start = 1'b0;
    wait_idle_b(100);
    push("to_timeout", 32'd1);  check(32'(b.timeout));
    push("to_done", 32'd0);     check(32'(b.done));
    push("to_count", 32'd8);    check(b.cycle_count);
    push("to_en_seen", 32'd8);  check(32'(en_b));
    tick(5);
    push("to_count_hold", 32'd8); check(b.cycle_count);

    // Step mode
    clear_monitors();
    a.step = 1'b1; tick(1); a.step = 1'b0;
    push("step_init_cpu_init", 32'd1); check(32'(a.cpu_init));
    tick(1);
    push("step_pause_cpu_init", 32'd0); check(32'(a.cpu_init));
    push("step_pause_cpu_en", 32'd0);   check(32'(a.cpu_en));
    push("step_pause_busy", 32'd1);     check(32'(a.busy));
    push("step_count_cleared", 32'd0);  check(a.cycle_count);
    for (int i = 0; i < 3; i++) begin
      a.step = 1'b1; tick(1); a.step = 1'b0;
      push("step_en_pulse", 32'd1); check(32'(a.cpu_en));
      tick(1);
      push("step_en_low", 32'd0);   check(32'(a.cpu_en));
    end
    push("step_count", 32'd3);            check(a.cycle_count);
    push("step_regpc", 32'h0040_000C);    check(a.regPC);
    push("step_en_seen", 32'd3);          check(32'(en_a));
    a.start = 1'b1; tick(1); a.start = 1'b0;
    wait_idle_a(200);
    push("step_resume_count", 32'd21); check(a.cycle_count);
    push("step_resume_done", 32'd1);   check(32'(a.done));

    // Pause / resume: halt issued at count 4, the halt cycle lands count at 5
    clear_monitors();
    a.start = 1'b1; tick(1); a.start = 1'b0;
    wait_count_a(32'd4, 50);
    a.halt_req = 1'b1; tick(1); a.halt_req = 1'b0;
    push("pause_count", 32'd5);  check(a.cycle_count);
    push("pause_cpu_en", 32'd0); check(32'(a.cpu_en));
    push("pause_busy", 32'd1);   check(32'(a.busy));
    e0 = en_a;
    tick(10);
    push("pause_count_hold", 32'd5);   check(a.cycle_count);
    push("pause_no_enables", 32'(e0)); check(32'(en_a));
    a.start = 1'b1; tick(1); a.start = 1'b0;
    wait_idle_a(200);
    push("resume_count", 32'd21);  check(a.cycle_count);
    push("resume_done", 32'd1);    check(32'(a.done));
    push("resume_timeout", 32'd0); check(32'(a.timeout));

    // Reset mid-run
    a.start = 1'b1; tick(1); a.start = 1'b0;
    wait_count_a(32'd7, 50);
    initPC = 1'b1;
    #1;
    push("midrst_cpu_init", 32'd1); check(32'(a.cpu_init));
    push("midrst_cpu_en", 32'd0);   check(32'(a.cpu_en));
    push("midrst_busy", 32'd0);     check(32'(a.busy));
    tick(1);
    initPC = 1'b0;
    #1;
    push("postrst_cpu_init", 32'd0); check(32'(a.cpu_init));
    push("postrst_count", 32'd0);    check(a.cycle_count);
    push("postrst_done", 32'd0);     check(32'(a.done));
    push("postrst_busy", 32'd0);     check(32'(a.busy));

    // Immediate limit: PC already at limit after INIT
    a.pc_lim = CPU_RESET_VEC;
    clear_monitors();
    a.start = 1'b1; tick(1); a.start = 1'b0;
    wait_idle_a(50);
    push("imm_done", 32'd1);    check(32'(a.done));
    push("imm_timeout", 32'd0); check(32'(a.timeout));
    push("imm_count", 32'd0);   check(a.cycle_count);
    push("imm_en_seen", 32'd0); check(32'(en_a));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
